// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic datapath blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SER_W = 8;

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout is the borrow out.
module serial_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int W = SER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int               CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       sr_a_q, sr_a_d;
    logic [W-1:0]       sr_b_q, sr_b_d;
    logic               bw_q, bw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic               bit_d;
    logic               bit_bo;
    logic [W-1:0]       sr_a_sh;
    logic [W-1:0]       sr_b_sh;

    serial_sub_cell u_cell (
        .x    (sr_a_q[0]),
        .y    (sr_b_q[0]),
        .bin  (bw_q),
        .d    (bit_d),
        .bout (bit_bo)
    );

    // Difference bits enter at the MSB so sr_a holds the full result after W shifts.
    if (W == 1) begin : g_w1
        assign sr_a_sh = bit_d;
        assign sr_b_sh = 1'b0;
    end else begin : g_wn
        assign sr_a_sh = {bit_d, sr_a_q[W-1:1]};
        assign sr_b_sh = {1'b0, sr_b_q[W-1:1]};
    end

    // Handshake: start is sampled only in IDLE; busy covers SHIFT and DONE;
    // done is a single-cycle pulse in DONE, with diff/borrow valid from then on.
    always_comb begin
        state_d  = state_q;
        sr_a_d   = sr_a_q;
        sr_b_d   = sr_b_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_a_d  = a;
                    sr_b_d  = b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
`endif
                end
            end
            SHIFT: begin
                sr_a_d = sr_a_sh;
                sr_b_d = sr_b_sh;
                bw_d   = bit_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = sr_a_sh;
                    borrow_d = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_a_q   <= '0;
            sr_b_q   <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sr_a_q   <= sr_a_d;
            sr_b_q   <= sr_b_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8 and W=1 instances); honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;

    logic         start8 = 1'b0;
    logic [W-1:0] a8     = '0;
    logic [W-1:0] b8     = '0;
    logic         busy8, done8, borrow8;
    logic [W-1:0] diff8;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         busy1, done1, borrow1;
    logic [0:0]   diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf8, ovf1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_bq[$];
    logic         exp_oq[$];

    serial_subtractor #(.W(W)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf8)
`endif
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf1)
`endif
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int r;
        r = int'(av) - int'(bv);
        return W'(r & 255);
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
        return int'(av) < int'(bv);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa, sb, r;
        sa = (int'(av) >= 128) ? int'(av) - 256 : int'(av);
        sb = (int'(bv) >= 128) ? int'(bv) - 256 : int'(bv);
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    // Driver: one operation on the W=8 instance, checking latency, busy span and result.
    task automatic run_op8(input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        int busy_n;
        bit seen;
        logic [W-1:0] ed;
        logic eb, eo;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        exp_q.push_back(model_diff(av, bv));
        exp_bq.push_back(model_borrow(av, bv));
        exp_oq.push_back(model_ovf(av, bv));
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (busy8) busy_n++;
            @(posedge clk); #1;
            if (done8) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (busy8) busy_n++;
        ed = exp_q.pop_front();
        eb = exp_bq.pop_front();
        eo = exp_oq.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL op_timeout a=%0d b=%0d: no done within 20 cycles, required done after %0d", av, bv, W);
        end else begin
            n_checks += 4;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL latency a=%0d b=%0d: got %0d cycles, expected %0d", av, bv, lat, W);
            end
            if (busy_n !== W + 1) begin
                n_fail++;
                $display("FAIL busy_span a=%0d b=%0d: got %0d cycles, expected %0d", av, bv, busy_n, W + 1);
            end
            if (diff8 !== ed) begin
                n_fail++;
                $display("FAIL diff a=%0d b=%0d: got %h, expected %h", av, bv, diff8, ed);
            end
            if (borrow8 !== eb) begin
                n_fail++;
                $display("FAIL borrow a=%0d b=%0d: got %b, expected %b", av, bv, borrow8, eb);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_checks++;
            if (ovf8 !== eo) begin
                n_fail++;
                $display("FAIL ovf a=%0d b=%0d: got %b, expected %b", av, bv, ovf8, eo);
            end
`endif
        end
        @(posedge clk); #1;
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse a=%0d b=%0d: done=%b busy=%b one cycle later, expected 0/0", av, bv, done8, busy8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== '0 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w8: busy=%b done=%b diff=%h borrow=%b, expected all 0", busy8, done8, diff8, borrow8);
        end
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || borrow1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w1: busy=%b done=%b diff=%b borrow=%b, expected all 0", busy1, done1, diff1, borrow1);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0 || ovf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf8=%b ovf1=%b, expected 0", ovf8, ovf1);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op8(8'd100, 8'd37);
        run_op8(8'd5, 8'd9);
        run_op8(8'h80, 8'h01);
        run_op8(8'h00, 8'h00);
        run_op8(8'hFF, 8'h00);
        run_op8(8'h7F, 8'hFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op8(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    endtask

    // A second start during SHIFT must be ignored: exactly one done with the first operands.
    task automatic test_restart();
        int ndone;
        logic [W-1:0] got;
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0; got = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                got = diff8;
            end
        end
        n_checks += 2;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL restart_done_count: got %0d done pulses, expected 1", ndone);
        end
        if (got !== model_diff(8'd50, 8'd20)) begin
            n_fail++;
            $display("FAIL restart_diff: got %h, expected %h", got, model_diff(8'd50, 8'd20));
        end
    endtask

    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || diff8 !== '0 || borrow8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b diff=%h borrow=%b, expected all 0", busy8, done8, diff8, borrow8);
        end
        ndone = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, expected 0", ndone);
        end
        run_op8(8'd7, 8'd7);
    endtask

    task automatic test_back_to_back();
        int t8[$];
        int t1[$];
        @(negedge clk);
        a8 = 8'd0; b8 = 8'd1; start8 = 1'b1;
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                t8.push_back(cyc);
                n_checks++;
                if (diff8 !== 8'hFF || borrow8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_w8_result: diff=%h borrow=%b, expected ff/1", diff8, borrow8);
                end
            end
            if (done1) begin
                t1.push_back(cyc);
                n_checks++;
                if (diff1 !== 1'b1 || borrow1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_w1_result: diff=%b borrow=%b, expected 1/1", diff1, borrow1);
                end
            end
        end
        @(negedge clk);
        start8 = 1'b0; start1 = 1'b0;
        n_checks += 2;
        if (t8.size() < 3) begin
            n_fail++;
            $display("FAIL b2b_w8_count: got %0d dones, expected at least 3", t8.size());
        end
        if (t1.size() < 10) begin
            n_fail++;
            $display("FAIL b2b_w1_count: got %0d dones, expected at least 10", t1.size());
        end
        for (int i = 1; i < t8.size(); i++) begin
            n_checks++;
            if (t8[i] - t8[i-1] !== W + 2) begin
                n_fail++;
                $display("FAIL b2b_w8_period: got %0d cycles, expected %0d", t8[i] - t8[i-1], W + 2);
            end
        end
        for (int i = 1; i < t1.size(); i++) begin
            n_checks++;
            if (t1[i] - t1[i-1] !== 3) begin
                n_fail++;
                $display("FAIL b2b_w1_period: got %0d cycles, expected 3", t1[i] - t1[i-1]);
            end
        end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
